// File: rtl/frame_buffer_writer.sv
// Framebuffer writer for the HUB75 scanner: single-pixel read-modify-write
// and full-screen fill of row-wide RAM words over a valid/ready handshake.
module frame_buffer_writer #(
    parameter int COLS        = 64,
    parameter int ROWS        = 64,
    parameter int COLOR_DEPTH = 1,
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int PW = 3 * COLOR_DEPTH,
    localparam int RW = COLS * PW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_clear,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [PW-1:0] i_color,
    output logic [YW-1:0] o_fb_address,
    input  logic [RW-1:0] i_fb_read_data,
    output logic [RW-1:0] o_fb_write_data,
    output logic          o_fb_write_enable,
    output logic          o_done
);

    localparam logic [XW:0]   COLS_L   = (XW + 1)'(COLS);
    localparam logic [YW:0]   ROWS_L   = (YW + 1)'(ROWS);
    localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);
    localparam logic [YW-1:0] PENULT   = YW'(ROWS - 2);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        CLEAR,
        SKIP
    } state_t;

    state_t        state;
    logic [XW-1:0] x_q;
    logic [PW-1:0] color_q;
    logic [RW-1:0] merged;
    logic          in_range;

    assign o_ready  = (state == IDLE) && !i_reset;
    assign in_range = ({1'b0, i_x} < COLS_L) && ({1'b0, i_y} < ROWS_L);

    // Only the addressed pixel slice changes; the rest of the row is passed through.
    always_comb begin
        merged = i_fb_read_data;
        merged[int'(x_q) * PW +: PW] = color_q;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            x_q               <= '0;
            color_q           <= '0;
            o_fb_address      <= '0;
            o_fb_write_data   <= '0;
            o_fb_write_enable <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_clear) begin
                            o_fb_address      <= '0;
                            o_fb_write_data   <= {COLS{i_color}};
                            o_fb_write_enable <= 1'b1;
                            o_done            <= (LAST_ROW == '0);
                            state             <= CLEAR;
                        end else if (in_range) begin
                            x_q          <= i_x;
                            color_q      <= i_color;
                            o_fb_address <= i_y;
                            state        <= READ;
                        end else begin
                            o_done <= 1'b1;
                            state  <= SKIP;
                        end
                    end
                end
                READ: state <= MERGE;
                MERGE: begin
                    o_fb_write_data   <= merged;
                    o_fb_write_enable <= 1'b1;
                    o_done            <= 1'b1;
                    state             <= WRITE;
                end
                WRITE: begin
                    o_fb_write_enable <= 1'b0;
                    o_done            <= 1'b0;
                    state             <= IDLE;
                end
                CLEAR: begin
                    // Terminates on the last row index, so non-power-of-two ROWS is fine.
                    if (o_fb_address == LAST_ROW) begin
                        o_fb_write_enable <= 1'b0;
                        o_done            <= 1'b0;
                        state             <= IDLE;
                    end else begin
                        o_fb_address <= o_fb_address + 1'b1;
                        o_done       <= (o_fb_address == PENULT);
                    end
                end
                SKIP: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed self-checking bench for frame_buffer_writer with a behavioural
// synchronous RAM; a second instance exercises COLOR_DEPTH=2.
module tb_frame_buffer_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0, clear = 1'b0;
    logic [5:0]   x = '0, y = '0;
    logic [2:0]   color = '0;
    logic         ready, we, done;
    logic [5:0]   addr;
    logic [191:0] rd, wd;

    logic         valid2 = 1'b0;
    logic [5:0]   x2 = '0, y2 = '0;
    logic [5:0]   color2 = '0;
    logic         ready2, we2, done2;
    logic [5:0]   addr2;
    logic [383:0] rd2 = '0, wd2;

    logic [191:0] mem [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[addr] <= wd;
        rd <= mem[addr];
    end

    frame_buffer_writer dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
        .i_clear(clear), .i_x(x), .i_y(y), .i_color(color),
        .o_fb_address(addr), .i_fb_read_data(rd), .o_fb_write_data(wd),
        .o_fb_write_enable(we), .o_done(done)
    );

    frame_buffer_writer #(.COLS(64), .ROWS(64), .COLOR_DEPTH(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid2), .o_ready(ready2),
        .i_clear(1'b0), .i_x(x2), .i_y(y2), .i_color(color2),
        .o_fb_address(addr2), .i_fb_read_data(rd2), .o_fb_write_data(wd2),
        .o_fb_write_enable(we2), .o_done(done2)
    );

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b required 1", name, ready);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ready, we, done} !== 3'b000 || addr !== 6'd0 || wd !== '0 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b done=%b addr=%0d wd_nonzero=%b required 0", ready, we, done, addr, |wd);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: ready=%b ready2=%b required 1", ready, ready2);
        end
    endtask

    // Issue a pixel request from a negedge and check cycle-by-cycle timing.
    task automatic pixel_req(input logic [5:0] px, input logic [5:0] py,
                             input logic [2:0] pc, input logic [191:0] expwd,
                             input string name);
        valid = 1'b1; clear = 1'b0; x = px; y = py; color = pc;
        wait_ready(name);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c <= 2) begin
                checks++;
                if (we !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early_c%0d: we=%b done=%b required 0", name, c, we, done);
                end
            end else if (c == 3) begin
                checks++;
                if (we !== 1'b1 || done !== 1'b1 || addr !== py) begin
                    errors++;
                    $display("FAIL %s_write_strobe: we=%b done=%b addr=%0d required 1 1 %0d", name, we, done, addr, py);
                end
                checks++;
                if (wd !== expwd) begin
                    errors++;
                    $display("FAIL %s_write_data: got %h required %h", name, wd, expwd);
                end
            end else begin
                checks++;
                if (ready !== 1'b1 || we !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_return_idle: ready=%b we=%b done=%b required 1 0 0", name, ready, we, done);
                end
            end
            if (c < 4) @(negedge clk);
        end
    endtask

    // Fill; when hold_valid is set, a pixel request is kept pending throughout.
    task automatic run_fill(input logic [2:0] fc, input logic hold_valid, input string name);
        logic [191:0] expw;
        int bad_we = 0, bad_addr = 0, bad_data = 0, bad_done = 0, bad_ready = 0;
        int bad_rows = 0;
        expw = {64{fc}};
        valid = 1'b1; clear = 1'b1; color = fc;
        wait_ready(name);
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) begin
            clear = 1'b0; x = 6'd5; y = 6'd3; color = 3'b100;
        end else begin
            valid = 1'b0;
        end
        for (int k = 1; k <= 64; k++) begin
            if (we !== 1'b1) bad_we++;
            if (addr !== 6'(k - 1)) bad_addr++;
            if (wd !== expw) bad_data++;
            if (done !== (k == 64)) bad_done++;
            if (ready !== 1'b0) bad_ready++;
            @(negedge clk);
        end
        checks++;
        if (bad_we != 0 || bad_addr != 0) begin
            errors++;
            $display("FAIL %s_we_addr_seq: bad_we=%0d bad_addr=%0d required 0 0", name, bad_we, bad_addr);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL %s_data: bad_cycles=%0d required 0", name, bad_data);
        end
        checks++;
        if (bad_done != 0 || bad_ready != 0) begin
            errors++;
            $display("FAIL %s_done_ready: bad_done=%0d bad_ready=%0d required 0 0", name, bad_done, bad_ready);
        end
        checks++;
        if (we !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: we=%b done=%b ready=%b required 0 0 1", name, we, done, ready);
        end
        for (int r = 0; r < 64; r++) if (mem[r] !== expw) bad_rows++;
        checks++;
        if (bad_rows != 0) begin
            errors++;
            $display("FAIL %s_ram_rows: bad_rows=%0d required 0", name, bad_rows);
        end
    endtask

    task automatic test_fill();
        run_fill(3'b111, 1'b0, "fill");
    endtask

    task automatic test_pixel_after_held_fill();
        logic [191:0] e;
        run_fill(3'b000, 1'b1, "held_fill");
        e = '0;
        e[17] = 1'b1;
        pixel_req(6'd5, 6'd3, 3'b100, e, "pixel");
        @(negedge clk);
        checks++;
        if (mem[3] !== e) begin
            errors++;
            $display("FAIL pixel_ram_row3: got %h required %h", mem[3], e);
        end
    endtask

    task automatic test_back_to_back();
        logic [191:0] e1, e2;
        e1 = '0;
        e1[0] = 1'b1;
        e2 = e1;
        e2[190] = 1'b1;
        pixel_req(6'd0, 6'd10, 3'b001, e1, "b2b_first");
        pixel_req(6'd63, 6'd10, 3'b010, e2, "b2b_second");
        @(negedge clk);
        checks++;
        if (mem[10] !== e2 || mem[9] !== '0 || mem[11] !== '0) begin
            errors++;
            $display("FAIL b2b_ram_row10: got %h required %h", mem[10], e2);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [191:0] f;
        int n = 0, bad = 0;
        f = {64{3'b010}};
        valid = 1'b1; clear = 1'b1; color = 3'b010;
        wait_ready("rst_fill");
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        while (addr != 6'd20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (addr !== 6'd20 || we !== 1'b1) begin
            errors++;
            $display("FAIL rst_fill_reach20: addr=%0d we=%b required 20 1", addr, we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (we !== 1'b0 || addr !== 6'd0 || ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_fill_async: we=%b addr=%0d ready=%b done=%b required 0 0 0 0", we, addr, ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL rst_fill_release: ready=%b we=%b required 1 0", ready, we);
        end
        for (int r = 0; r < 64; r++) begin
            if (r < 20 && mem[r] !== f) bad++;
            if (r >= 20 && mem[r] !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_fill_rows: bad_rows=%0d required 0", bad);
        end
    endtask

    task automatic test_color_depth2();
        logic [383:0] e;
        int n = 0;
        rd2 = {96{4'b1010}};
        e = rd2;
        e[11:6] = 6'b110110;
        valid2 = 1'b1; x2 = 6'd1; y2 = 6'd0; color2 = 6'b110110;
        while (!ready2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (we2 !== 1'b1 || done2 !== 1'b1) begin
            errors++;
            $display("FAIL cd2_strobe: we=%b done=%b required 1 1", we2, done2);
        end
        checks++;
        if (wd2 !== e) begin
            errors++;
            $display("FAIL cd2_write_data: got %h required %h", wd2, e);
        end
        @(negedge clk);
        checks++;
        if (ready2 !== 1'b1 || we2 !== 1'b0) begin
            errors++;
            $display("FAIL cd2_return_idle: ready=%b we=%b required 1 0", ready2, we2);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pixel_after_held_fill();
        test_back_to_back();
        test_reset_mid_fill();
        test_color_depth2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
